ctrl_seq: RTL and testbench

CTRL_SEQ -- requirements
Module: ctrl_seq

---
 rtl/salamander_pkg.sv | 39 +++
 rtl/salamander_alu.sv | 42 ++++
 rtl/ctrl_seq.sv | 131 +++++++++++++
 tb/tb_ctrl_seq.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/salamander_pkg.sv
// Shared types and constants for the salamander control sequencer:
// opcode and FSM state encodings plus small opcode-classification helpers.
package salamander_pkg;

  localparam int DATA_W = 8;
  localparam int RF_AW  = 4;
  localparam int PC_W   = 8;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_LD  = 4'h2,
    OP_ST  = 4'h3,
    OP_ADD = 4'h4,
    OP_SUB = 4'h5,
    OP_AND = 4'h6,
    OP_JZ  = 4'h7,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  // Opcodes whose result lands in ACC and refreshes ZERO.
  function automatic logic writes_acc(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_LD) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_AND);
  endfunction

  function automatic logic writes_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/salamander_alu.sv
// Combinational datapath for the sequencer: computes the next accumulator
// value, carry/borrow and zero flag for the opcode being executed.
module salamander_alu
  import salamander_pkg::*;
(
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  input  logic [3:0]        opcode,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // The extra MSB holds carry-out for ADD and borrow (acc < operand) for SUB.
  assign sum  = {1'b0, acc} + {1'b0, operand};
  assign diff = {1'b0, acc} - {1'b0, operand};

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    result = acc;
    carry  = 1'b0;
    case (opcode)
      OP_LDI, OP_LD: result = operand;
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
      end
      OP_AND: result = acc & operand;
      default: ;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ctrl_seq.sv
// Fetch/decode/execute sequencer: fetches 8-bit instructions from program
// memory, reads a registered-latency register file and runs a tiny ALU.
module ctrl_seq
  import salamander_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              RUN,
  output logic              PM_REQ,
  output logic [PC_W-1:0]   PM_ADDR,
  input  logic              PM_ACK,
  input  logic [DATA_W-1:0] PM_DATA,
  output logic [RF_AW-1:0]  RF_ADDR,
  output logic              RF_CE,
  output logic [DATA_W-1:0] RF_WDATA,
  input  logic [DATA_W-1:0] RF_RDATA,
  output logic [DATA_W-1:0] ACC_OUT,
  output logic              ZERO,
  output logic              CARRY,
  output logic              HALTED
);

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] acc;

  logic [3:0]        op;
  logic [3:0]        imm;
  logic [DATA_W-1:0] alu_operand;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;

  assign op  = ir[7:4];
  assign imm = ir[3:0];

  // LDI takes its operand from the instruction; every other ALU op from the RF.
  assign alu_operand = (op == OP_LDI) ? {4'h0, imm} : RF_RDATA;

  salamander_alu u_alu (
    .acc     (acc),
    .operand (alu_operand),
    .opcode  (op),
    .result  (alu_result),
    .carry   (alu_carry),
    .zero    (alu_zero)
  );

  assign PM_ADDR  = pc;
  assign RF_WDATA = acc;
  assign ACC_OUT  = acc;

  // NOTE: sequential state uses non-blocking assignments only, and every
  // register (outputs included) sits in the async reset so RSTN clears it
  // without needing a clock edge.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      ir      <= '0;
      acc     <= '0;
      ZERO    <= 1'b0;
      CARRY   <= 1'b0;
      RF_ADDR <= '0;
      RF_CE   <= 1'b0;
      PM_REQ  <= 1'b0;
      HALTED  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (RUN) begin
            state  <= S_FETCH;
            PM_REQ <= 1'b1;
          end
        end

        // Request and address stay put until memory acknowledges; RUN is
        // deliberately not looked at here so a pending fetch always completes.
        S_FETCH: begin
          if (PM_ACK) begin
            ir      <= PM_DATA;
            RF_ADDR <= {2'b00, PM_DATA[1:0]};
            pc      <= pc + 8'd1;
            PM_REQ  <= 1'b0;
            state   <= S_DECODE;
          end
        end

        // RF_ADDR is held so the registered RF read is valid during EXEC.
        S_DECODE: begin
          RF_CE <= (op == OP_ST);
          state <= S_EXEC;
        end

        S_EXEC: begin
          RF_CE <= 1'b0;
          if (writes_acc(op)) begin
            acc  <= alu_result;
            ZERO <= alu_zero;
          end
          if (writes_carry(op)) begin
            CARRY <= alu_carry;
          end
          // Jump target keeps the upper nibble of the already-incremented PC.
          if ((op == OP_JZ) && ZERO) begin
            pc <= {pc[7:4], imm};
          end
          if (op == OP_HLT) begin
            state  <= S_HALT;
            HALTED <= 1'b1;
          end else if (RUN) begin
            state  <= S_FETCH;
            PM_REQ <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end

        S_HALT: begin
          HALTED <= 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: table-driven ALU/flag vectors plus
// directed sequences for fetch handshake, jumps, halt, RUN drop and reset.
module tb_ctrl_seq;

  localparam logic [7:0] RST_PC = 8'hF0;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       RUN = 1'b0;
  logic       PM_REQ;
  logic [7:0] PM_ADDR;
  logic       PM_ACK;
  logic [7:0] PM_DATA;
  logic [3:0] RF_ADDR;
  logic       RF_CE;
  logic [7:0] RF_WDATA;
  logic [7:0] RF_RDATA;
  logic [7:0] ACC_OUT;
  logic       ZERO;
  logic       CARRY;
  logic       HALTED;

  ctrl_seq #(.RESET_PC(RST_PC)) dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .RUN      (RUN),
    .PM_REQ   (PM_REQ),
    .PM_ADDR  (PM_ADDR),
    .PM_ACK   (PM_ACK),
    .PM_DATA  (PM_DATA),
    .RF_ADDR  (RF_ADDR),
    .RF_CE    (RF_CE),
    .RF_WDATA (RF_WDATA),
    .RF_RDATA (RF_RDATA),
    .ACC_OUT  (ACC_OUT),
    .ZERO     (ZERO),
    .CARRY    (CARRY),
    .HALTED   (HALTED)
  );

  always #5 CLK = ~CLK;

  // Program memory: acknowledges a request after ack_delay wait cycles.
  logic [7:0] pm [256];
  int         ack_delay = 0;
  logic [7:0] wait_cnt = 8'd0;

  assign PM_ACK  = PM_REQ && (int'(wait_cnt) >= ack_delay);
  assign PM_DATA = pm[PM_ADDR];

  always @(posedge CLK) begin
    if (PM_REQ && !PM_ACK) wait_cnt <= wait_cnt + 8'd1;
    else                   wait_cnt <= 8'd0;
  end

  // Register file with one-cycle registered read; writes are applied by the run task.
  logic [7:0] rf [16];
  logic [7:0] rf_rdata_q = 8'd0;
  always @(posedge CLK) rf_rdata_q <= rf[RF_ADDR];
  assign RF_RDATA = rf_rdata_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) pm[i] = 8'h00;
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
  endtask

  task automatic do_reset();
    RUN = 1'b0;
    @(negedge CLK);
    RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
  endtask

  // Run until HALTED, logging accepted fetch addresses and RF write pulses.
  logic [7:0] fetch_log [64];
  int         fetch_n;
  int         ce_n;
  logic [7:0] ce_data;
  logic [3:0] ce_addr;

  task automatic run_until_halt(input int budget);
    fetch_n = 0;
    ce_n    = 0;
    ce_data = 8'h00;
    ce_addr = 4'h0;
    for (int c = 0; c < budget; c++) begin
      @(negedge CLK);
      if (PM_REQ && PM_ACK && fetch_n < 64) begin
        fetch_log[fetch_n] = PM_ADDR;
        fetch_n++;
      end
      if (RF_CE) begin
        ce_n++;
        ce_data = RF_WDATA;
        ce_addr = RF_ADDR;
        rf[RF_ADDR] = RF_WDATA;
      end
      if (HALTED) break;
    end
    check("halt_reached", 8'(HALTED), 8'd1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] pre;
    logic [7:0] op;
    logic [7:0] e_acc;
    logic       e_zero;
    logic       e_carry;
  } vec_t;

  vec_t vecs [17];

  initial begin
    int         req_cycles;
    int         late_req;
    logic       addr_ok;
    logic       seen_drop;

    // Program per vector: F0 LD 0 ; F1 pre ; F2 op ; F3 HLT  (rf0=a, rf1=b, rf2=c)
    vecs[0]  = '{8'h05, 8'h03, 8'h00, 8'h00, 8'h41, 8'h08, 1'b0, 1'b0};
    vecs[1]  = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h41, 8'h00, 1'b1, 1'b1};
    vecs[2]  = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h51, 8'hFF, 1'b0, 1'b1};
    vecs[3]  = '{8'h05, 8'h05, 8'h00, 8'h00, 8'h51, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{8'hF0, 8'h3C, 8'h00, 8'h00, 8'h61, 8'h30, 1'b0, 1'b0};
    vecs[5]  = '{8'h0F, 8'hF0, 8'h00, 8'h00, 8'h61, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h1A, 8'h0A, 1'b0, 1'b0};
    vecs[7]  = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{8'hFF, 8'h00, 8'h01, 8'h42, 8'h15, 8'h05, 1'b0, 1'b1};
    vecs[9]  = '{8'hFF, 8'h00, 8'h01, 8'h42, 8'h61, 8'h00, 1'b1, 1'b1};
    vecs[10] = '{8'h80, 8'h7F, 8'h00, 8'h00, 8'h41, 8'hFF, 1'b0, 1'b0};
    vecs[11] = '{8'h80, 8'h80, 8'h00, 8'h00, 8'h41, 8'h00, 1'b1, 1'b1};
    vecs[12] = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h21, 8'h80, 1'b0, 1'b0};
    vecs[13] = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h80, 8'h05, 1'b0, 1'b0};
    vecs[14] = '{8'h10, 8'h01, 8'h00, 8'h00, 8'h51, 8'h0F, 1'b0, 1'b0};
    vecs[15] = '{8'hFF, 8'h00, 8'h01, 8'h42, 8'h51, 8'h00, 1'b1, 1'b0};
    vecs[16] = '{8'hFF, 8'h00, 8'h01, 8'h42, 8'h00, 8'h00, 1'b1, 1'b1};

    clear_mem();

    // Reset state, idle while RUN=0, first edge after RUN evaluates IDLE.
    do_reset();
    check("rst_pm_req",  8'(PM_REQ),  8'd0);
    check("rst_pm_addr", PM_ADDR,     RST_PC);
    check("rst_acc",     ACC_OUT,     8'h00);
    check("rst_zero",    8'(ZERO),    8'd0);
    check("rst_carry",   8'(CARRY),   8'd0);
    check("rst_rf_ce",   8'(RF_CE),   8'd0);
    check("rst_rf_addr", 8'(RF_ADDR), 8'd0);
    check("rst_halted",  8'(HALTED),  8'd0);
    repeat (4) @(negedge CLK);
    check("idle_no_req", 8'(PM_REQ),  8'd0);
    RUN = 1'b1;
    @(negedge CLK);
    check("idle_to_fetch", 8'(PM_REQ), 8'd1);

    // Table-driven ALU and flag vectors.
    ack_delay = 0;
    for (int v = 0; v < 17; v++) begin
      clear_mem();
      pm[8'hF0] = 8'h20;
      pm[8'hF1] = vecs[v].pre;
      pm[8'hF2] = vecs[v].op;
      pm[8'hF3] = 8'hF0;
      rf[0] = vecs[v].a;
      rf[1] = vecs[v].b;
      rf[2] = vecs[v].c;
      do_reset();
      RUN = 1'b1;
      run_until_halt(100);
      check($sformatf("vec%0d_acc", v),   ACC_OUT,  vecs[v].e_acc);
      check($sformatf("vec%0d_zero", v),  8'(ZERO), 8'(vecs[v].e_zero));
      check($sformatf("vec%0d_carry", v), 8'(CARRY), 8'(vecs[v].e_carry));
    end

    // LDI 5; ST 1; LDI 3; ADD 1; HLT
    clear_mem();
    pm[8'hF0] = 8'h15;
    pm[8'hF1] = 8'h31;
    pm[8'hF2] = 8'h13;
    pm[8'hF3] = 8'h41;
    pm[8'hF4] = 8'hF0;
    do_reset();
    RUN = 1'b1;
    run_until_halt(100);
    check("prog_ce_pulses", 8'(ce_n),    8'd1);
    check("prog_ce_wdata",  ce_data,     8'h05);
    check("prog_ce_addr",   8'(ce_addr), 8'd1);
    check("prog_acc",       ACC_OUT,     8'h08);
    check("prog_carry",     8'(CARRY),   8'd0);
    check("prog_zero",      8'(ZERO),    8'd0);
    check("prog_halted",    8'(HALTED),  8'd1);
    RUN = 1'b0;
    repeat (3) @(negedge CLK);
    RUN = 1'b1;
    repeat (3) @(negedge CLK);
    check("halt_sticky",  8'(HALTED), 8'd1);
    check("halt_no_req",  8'(PM_REQ), 8'd0);
    check("halt_no_ce",   8'(RF_CE),  8'd0);

    // Delayed acknowledge: request and address held for all four cycles.
    clear_mem();
    ack_delay = 3;
    do_reset();
    RUN = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (PM_REQ) break;
    end
    check("dly_req_seen", 8'(PM_REQ), 8'd1);
    req_cycles = 0;
    addr_ok    = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (!PM_REQ) break;
      req_cycles++;
      if (PM_ADDR !== RST_PC) addr_ok = 1'b0;
      @(negedge CLK);
    end
    check("dly_req_cycles", 8'(req_cycles), 8'd4);
    check("dly_addr_stable", 8'(addr_ok), 8'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (PM_REQ) break;
    end
    check("dly_next_addr", PM_ADDR, 8'hF1);

    // PC wrap FF->00, JZ taken at 0x12, JZ not taken at 0x15.
    clear_mem();
    ack_delay = 0;
    pm[8'h11] = 8'h10;
    pm[8'h12] = 8'h74;
    pm[8'h14] = 8'h11;
    pm[8'h15] = 8'h78;
    pm[8'h16] = 8'hF0;
    do_reset();
    RUN = 1'b1;
    run_until_halt(400);
    check("jmp_fetch_count", 8'(fetch_n), 8'd38);
    check("jmp_at_ff",       fetch_log[15], 8'hFF);
    check("jmp_wrap_00",     fetch_log[16], 8'h00);
    check("jmp_at_12",       fetch_log[34], 8'h12);
    check("jz_taken",        fetch_log[35], 8'h14);
    check("jz_src_15",       fetch_log[36], 8'h15);
    check("jz_not_taken",    fetch_log[37], 8'h16);
    check("jmp_acc",         ACC_OUT,       8'h01);

    // Asynchronous reset in the middle of a pending fetch.
    clear_mem();
    ack_delay = 2;
    pm[8'hF0] = 8'h20;
    pm[8'hF1] = 8'h41;
    pm[8'hF2] = 8'h17;
    rf[0] = 8'hFF;
    rf[1] = 8'h01;
    do_reset();
    RUN = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (PM_REQ && PM_ADDR == 8'hF3) break;
    end
    check("mid_pre_req",   8'(PM_REQ), 8'd1);
    check("mid_pre_acc",   ACC_OUT,    8'h07);
    check("mid_pre_carry", 8'(CARRY),  8'd1);
    #2 RSTN = 1'b0;
    #1;
    check("mid_rst_req",   8'(PM_REQ), 8'd0);
    check("mid_rst_acc",   ACC_OUT,    8'h00);
    check("mid_rst_carry", 8'(CARRY),  8'd0);
    check("mid_rst_zero",  8'(ZERO),   8'd0);
    check("mid_rst_addr",  PM_ADDR,    RST_PC);
    @(negedge CLK);
    RSTN = 1'b1;

    // RUN dropped during FETCH: instruction completes, then IDLE.
    clear_mem();
    ack_delay = 2;
    pm[8'hF0] = 8'h19;
    do_reset();
    RUN = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (PM_REQ) break;
    end
    check("drop_req_seen", 8'(PM_REQ), 8'd1);
    RUN = 1'b0;
    seen_drop = 1'b0;
    late_req  = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (!PM_REQ) seen_drop = 1'b1;
      else if (seen_drop) late_req++;
    end
    check("drop_no_refetch", 8'(late_req), 8'd0);
    check("drop_acc",        ACC_OUT,      8'h09);
    check("drop_pc",         PM_ADDR,      8'hF1);
    check("drop_not_halted", 8'(HALTED),   8'd0);
    RUN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (PM_REQ) break;
    end
    check("drop_resume_req",  8'(PM_REQ), 8'd1);
    check("drop_resume_addr", PM_ADDR,    8'hF1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
